// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Dwell counter: counts settle cycles for one input vector and flags the
// last settle cycle (count == DWELL-2) so the next cycle can sample.
module dwell_counter
    import truth_sweep_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    logic [CNT_W-1:0] r_count;

    // Count settle cycles; clear has priority over enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_term = (r_count == CNT_W'(DWELL - 2));

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 A..D combinations in ascending order,
// holds each for DWELL cycles, samples y on the last cycle and builds a
// 16-bit truth table with its minterm count.
// Optional feature: define TRUTH_SWEEP_COMPARE_EN to compare the captured
// table against the expected input at the end of each sweep.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        table_valid,
    output logic [4:0]  ones_count,
    output logic        mismatch
);

    state_t           r_state;
    state_t           w_next;
    logic [VEC_W-1:0] r_vec;
    logic [15:0]      r_table;
    logic [4:0]       r_ones;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_mismatch;
    logic             w_term;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_term (w_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and dwell counter control.
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (start) begin
                    w_next = SETTLE;
                end else begin
                    w_next = IDLE;
                end
            end
            SETTLE: begin
                w_cnt_en = 1'b1;
                if (w_term) begin
                    w_next = SAMPLE;
                end else begin
                    w_next = SETTLE;
                end
            end
            SAMPLE: begin
                w_cnt_clr = 1'b1;
                if (r_vec == LAST_VEC) begin
                    w_next = DONE;
                end else begin
                    w_next = SETTLE;
                end
            end
            DONE: begin
                w_cnt_clr = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_cnt_clr = 1'b1;
                w_next    = IDLE;
            end
        endcase
    end

    // Datapath: vector drive, table capture and registered status outputs.
    // busy/done are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec      <= {VEC_W{1'b0}};
            r_table    <= 16'h0000;
            r_ones     <= 5'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_busy <= (w_next == SETTLE) || (w_next == SAMPLE);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec      <= {VEC_W{1'b0}};
                        r_table    <= 16'h0000;
                        r_ones     <= 5'd0;
                        r_valid    <= 1'b0;
                        r_mismatch <= 1'b0;
                    end
                end
                SAMPLE: begin
                    r_table[r_vec] <= y;
                    r_ones         <= r_ones + {4'd0, y};
                    if (r_vec != LAST_VEC) begin
                        r_vec <= r_vec + {{(VEC_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    r_valid <= 1'b1;
                    // Return the drive to 0000 for IDLE.
                    r_vec   <= {VEC_W{1'b0}};
`ifdef TRUTH_SWEEP_COMPARE_EN
                    r_mismatch <= (r_table != expected);
`else
                    r_mismatch <= 1'b0;
`endif
                end
                default: begin
                    r_vec <= r_vec;
                end
            endcase
        end
    end

`ifndef TRUTH_SWEEP_COMPARE_EN
    // expected has no consumer when the comparator is not built.
    logic w_unused_expected;
    assign w_unused_expected = ^expected;
`endif

    assign a           = r_vec[3];
    assign b           = r_vec[2];
    assign c           = r_vec[1];
    assign d           = r_vec[0];
    assign busy        = r_busy;
    assign done        = r_done;
    assign table_out   = r_table;
    assign table_valid = r_valid;
    assign ones_count  = r_ones;
    assign mismatch    = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with DWELL = 4. A small Boolean
// block selected by mode drives y from a..d.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst;
    logic        start;
    logic        y;
    logic [15:0] expected;
    logic        a, b, c, d;
    logic        busy, done, table_valid, mismatch;
    logic [15:0] table_out;
    logic [4:0]  ones_count;
    int          mode;
    int          n_checks;
    int          n_bad;
    int          done_cycle, busy_first, busy_last, vec_err;

    truth_table_sweeper #(.DWELL(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .y           (y),
        .expected    (expected),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .busy        (busy),
        .done        (done),
        .table_out   (table_out),
        .table_valid (table_valid),
        .ones_count  (ones_count),
        .mismatch    (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream Boolean block under sweep.
    always_comb begin
        y = 1'b0;
        case (mode)
            0:       y = a & b;
            1:       y = a ^ b ^ c ^ d;
            2:       y = 1'b1;
            default: y = 1'b0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep from IDLE; optionally re-pulses start during cycles 10 and 30.
    task automatic sweep(input string tag, input int mode_i, input logic [15:0] exp_i,
                         input logic [15:0] tbl, input logic [4:0] ones, input bit repulse);
        logic mm_exp;
        mode       = mode_i;
        expected   = exp_i;
        done_cycle = 0;
        busy_first = 0;
        busy_last  = 0;
        vec_err    = 0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            if (busy) begin
                if (busy_first == 0) busy_first = t;
                busy_last = t;
            end
            if (done && done_cycle == 0) done_cycle = t;
            if (t <= 64) begin
                if ({a, b, c, d} !== 4'((t - 1) / 4)) vec_err++;
            end
            if (done_cycle != 0) break;
            start = repulse && (t == 9 || t == 29);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq({tag, "_done_cycle"}, done_cycle, 65);
        check_eq({tag, "_busy_first"}, busy_first, 1);
        check_eq({tag, "_busy_last"}, busy_last, 64);
        check_eq({tag, "_vec_order"}, vec_err, 0);
        @(posedge clk); #1;
`ifdef TRUTH_SWEEP_COMPARE_EN
        mm_exp = (tbl != exp_i);
`else
        mm_exp = 1'b0;
`endif
        check_eq({tag, "_table"}, table_out, tbl);
        check_eq({tag, "_ones"}, ones_count, ones);
        check_eq({tag, "_valid"}, table_valid, 1);
        check_eq({tag, "_mismatch"}, mismatch, mm_exp);
        check_eq({tag, "_idle_abcd"}, {a, b, c, d}, 0);
    endtask

    initial begin
        int d1, d2;
        n_checks = 0;
        n_bad    = 0;
        mode     = 0;
        expected = 16'h0000;
        rst      = 1'b1;
        start    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_abcd", {a, b, c, d}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_table", table_out, 16'h0000);
        check_eq("rst_valid", table_valid, 0);
        check_eq("rst_ones", ones_count, 0);
        check_eq("rst_mismatch", mismatch, 0);

        sweep("and",    0, 16'hF000, 16'hF000, 5'd4,  1'b0);
        sweep("par",    1, 16'h6996, 16'h6996, 5'd8,  1'b0);
        sweep("par_bad",1, 16'h6997, 16'h6996, 5'd8,  1'b0);
        sweep("ones",   2, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0);
        sweep("zeros",  3, 16'h0000, 16'h0000, 5'd0,  1'b0);
        sweep("repulse",0, 16'hF000, 16'hF000, 5'd4,  1'b1);

        // Results hold in IDLE.
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_table", table_out, 16'hF000);
        check_eq("hold_valid", table_valid, 1);
        check_eq("hold_busy", busy, 0);

        // Reset during cycle 20 of a parity sweep.
        mode  = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_eq("pre_rst_table", table_out, 16'h0006);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_abcd", {a, b, c, d}, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_table", table_out, 16'h0000);
        check_eq("mid_rst_valid", table_valid, 0);
        check_eq("mid_rst_ones", ones_count, 0);
        sweep("after_rst", 1, 16'h6996, 16'h6996, 5'd8, 1'b0);

        // start held high: back-to-back sweeps.
        mode  = 0;
        d1    = 0;
        d2    = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 300; t++) begin
            if (done) begin
                if (d1 == 0) d1 = t;
                else if (d2 == 0) d2 = t;
            end
            if (d2 != 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("b2b_first_done", d1, 65);
        check_eq("b2b_period", d2 - d1, 66);
        @(posedge clk); #1;
        check_eq("b2b_table", table_out, 16'hF000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational Boolean block. On a start pulse it drives all 16 input combinations of A, B, C and D in ascending order and holds each one for a programmable dwell. It samples the block's Y output for each combination and assembles a 16-bit truth table plus a minterm count. This replaces hand-written exhaustive stimulus with a reusable, self-timed sweep usable in both simulation and hardware.

## Interface
- DWELL, 4, cycles each input vector is held (must be ≥ 2); Y is sampled on the last cycle.
- CNT_W, 8, width of the dwell counter; must satisfy DWELL ≤ 2^CNT_W.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begins a sweep when sampled high in IDLE; ignored otherwise.
- y  input  1  output of the downstream Boolean block under sweep.
- expected  input  16  golden truth table; used only with the compare feature.
- a, b, c, d  output  1 each  drive signals; a = vec[3], b = vec[2], c = vec[1], d = vec[0].
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  single-cycle pulse when a sweep completes.
- table_out  output  16  captured table; bit k = y sampled when vec = k.
- table_valid  output  1  table_out complete and stable.
- ones_count  output  5  number of set bits in table_out (range 0..16).
- mismatch  output  1  table_out ≠ expected (compare feature).

## Operation
- Registered state machine with four states:
  - IDLE: a..d = 0; busy = 0. If start = 1, go to SETTLE with vec = 0, counter = 0, table_out = 0, table_valid = 0, ones_count = 0, mismatch = 0.
  - SETTLE: drive vec; counter increments each cycle. When counter = DWELL-2, go to SAMPLE.
  - SAMPLE: one cycle. table_out[vec] ← y and ones_count += y.
    - If vec = 15, go to DONE.
    - Otherwise vec ← vec+1, counter ← 0, go to SETTLE.
  - DONE: one cycle. done = 1, table_valid ← 1, and mismatch evaluates with the compare feature. Then go to IDLE.
- a..d are registered and change only on the SETTLE-entry edge, so they stay constant across the whole dwell including SAMPLE.
- vec is a 4-bit counter that never wraps inside a sweep; the value 15 terminates it.
- ones_count saturates naturally at 16 and needs no overflow handling.
- start while busy or in DONE: ignored, with no restart.
- start in the IDLE cycle right after DONE: accepted, and the table clears.
- table_out, table_valid, ones_count and mismatch hold their values in IDLE until the next accepted start.
- rst (any state, including mid-sweep): state → IDLE and every output goes to its reset value; the partial table is discarded.

## Timing
- Reset values: a = b = c = d = 0, busy = 0, done = 0, table_out = 16'h0000, table_valid = 0, ones_count = 0, mismatch = 0.
- Start accepted at edge 0:
  - busy rises in cycle 1.
  - Vector k is driven from cycle DWELL·k+1 and sampled at edge DWELL·k+DWELL.
  - done pulses in cycle 16·DWELL+1.
  - busy falls in the same cycle that done pulses.
- The downstream block has DWELL-1 full cycles to settle before it is sampled.
- Throughput: one sweep per 16·DWELL+2 cycles when start is held high.

## Configuration
- TRUTH_SWEEP_COMPARE_EN defined: in DONE, mismatch ← (table_out ≠ expected) and holds until the next start.
- Not defined: expected is ignored, mismatch is tied to 0, and the comparator logic is absent.

## Structure
- Package truth_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS = 16;
  - a localparam for the vec width (4).
- Sub-module dwell_counter (CNT_W-bit, with clear and enable, and a terminal flag at DWELL-2). It is instantiated once; everything else stays in truth_table_sweeper.

## Test plan
- y wired to a&b, DWELL = 4, start pulse → table_out = 16'hF000, ones_count = 4, done pulses in cycle 65 after start, busy high in cycles 1–64.
- y wired to a^b^c^d → table_out = 16'h6996, ones_count = 8; with TRUTH_SWEEP_COMPARE_EN and expected = 16'h6996 → mismatch = 0; with expected = 16'h6997 → mismatch = 1.
- y tied to 1, then tied to 0 → table_out = 16'hFFFF with ones_count = 16, then 16'h0000 with ones_count = 0; table_valid = 1 after each sweep.
- start re-pulsed at cycles 10 and 30 of a sweep → ignored; done still occurs only in cycle 65 and the table is unchanged.
- rst asserted for one cycle at cycle 20 → next cycle a..d = 0, busy = 0, table_out = 0, table_valid = 0; a fresh start completes normally.
- Check a..d against the sampling cycle → values are stable for exactly DWELL cycles per vector and follow the order 0000 → 1111.
